// File: rtl/key_event_service_ctrl.sv
// Services the key PIO edge-capture register in hardware: reads it on irq or poll tick, clears it,
// and queues each nonzero capture word in a first-word-fall-through event FIFO.
module key_event_service_ctrl #(
    parameter logic [3:0]  INIT_MASK   = 4'hF,
    parameter int unsigned POLL_PERIOD = 0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        irq_in,
    input  logic        cfg_mask_wr,
    input  logic [3:0]  cfg_mask,
    output logic        ev_valid,
    output logic [3:0]  ev_data,
    input  logic        ev_ready,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic        busy
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0] POLL_LAST = (POLL_PERIOD == 0) ? 32'd0 : 32'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_MASK, S_RD_ADDR, S_RD_DATA, S_CLR, S_PUSH
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    addr_q, addr_d;
    logic          cs_q, cs_d;
    logic          wn_q, wn_d;
    logic [3:0]    wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic [3:0]    cap_q, cap_d;
    logic          pend_q, pend_d;
    logic [3:0]    pmask_q, pmask_d;
    logic [31:0]   poll_q, poll_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [3:0]    mem_q [FIFO_DEPTH];

    logic poll_tick, push_req, pop, full, push_ok, drop;
    logic unused_rdata;

    assign unused_rdata = ^m_readdata[31:4];

    always_comb begin
        poll_tick = (POLL_PERIOD != 0) && (state_q == S_IDLE) && (poll_q == POLL_LAST);
        state_d   = state_q;
        cap_d     = cap_q;
        case (state_q)
            S_INIT:    state_d = S_IDLE;
            S_IDLE: begin
                if (pend_q)                      state_d = S_MASK;
                else if (irq_in || poll_tick)    state_d = S_RD_ADDR;
            end
            S_MASK:    state_d = S_IDLE;
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: begin
                cap_d   = m_readdata[3:0];
                state_d = (m_readdata[3:0] == 4'h0) ? S_IDLE : S_CLR;
            end
            S_CLR:     state_d = S_PUSH;
            S_PUSH:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Bus registers carry the action of the state being entered, so each access lines up
        // with its state; INIT is the exception, its write lands in the cycle after reset.
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = '0;
        wdata_d = '0;
        if (state_q == S_INIT) begin
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            addr_d  = 2'd2;
            wdata_d = INIT_MASK;
        end else begin
            case (state_d)
                S_MASK: begin
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    addr_d  = 2'd2;
                    wdata_d = pmask_q;
                end
                S_RD_ADDR: begin
                    cs_d   = 1'b1;
                    addr_d = 2'd3;
                end
                S_CLR: begin
                    cs_d   = 1'b1;
                    wn_d   = 1'b0;
                    addr_d = 2'd3;
                end
                default: ;
            endcase
        end

        busy_d  = (state_d != S_IDLE);
        pmask_d = cfg_mask_wr ? cfg_mask : pmask_q;
        if (cfg_mask_wr)                                  pend_d = 1'b1;
        else if (state_q == S_IDLE && state_d == S_MASK)  pend_d = 1'b0;
        else                                              pend_d = pend_q;
        poll_d = ((POLL_PERIOD != 0) && state_q == S_IDLE && state_d == S_IDLE) ? poll_q + 32'd1 : '0;
    end

    // The push lands on the edge leaving CLR so the event is already visible during PUSH.
    always_comb begin
        push_req = (state_q == S_CLR);
        pop      = ev_valid && ev_ready;
        full     = (cnt_q == FULL_CNT);
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = drop | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_INIT;
            addr_q   <= '0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            wdata_q  <= '0;
            busy_q   <= 1'b1;
            cap_q    <= '0;
            pend_q   <= 1'b0;
            pmask_q  <= '0;
            poll_q   <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            cap_q    <= cap_d;
            pend_q   <= pend_d;
            pmask_q  <= pmask_d;
            poll_q   <= poll_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= cap_q;
    end

    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_writedata  = {28'd0, wdata_q};
    assign busy         = busy_q;
    assign overflow     = ovf_q;
    assign ev_valid     = (cnt_q != '0);
    assign ev_data      = ev_valid ? mem_q[rd_ptr_q] : '0;
endmodule
